// File: rtl/muldiv_wb_merge.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_wb_merge
// Brief   : Buffers muldiv_unit results in a small FIFO and merges them into
//           the shared regfile write port behind pipeline writeback; keeps a
//           per-hart outstanding-muldiv scoreboard. Define MULDIV_WB_BYPASS_EN
//           for a same-cycle result bypass when the port and FIFO are idle.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 1
`endif
`ifndef HART_NUM
`define HART_NUM 2
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module muldiv_wb_merge #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 muldiv_start,
    input  logic [`HART_ID_W-1:0]                muldiv_hart_id,
    input  logic [`REG_ADDR_W-1:0]               muldiv_rd,
    input  logic                                 muldiv_done,
    input  logic [`XLEN-1:0]                     muldiv_result,
    input  logic [`HART_ID_W-1:0]                muldiv_done_hart_id,
    input  logic [`REG_ADDR_W-1:0]               muldiv_done_rd,
    input  logic                                 pipe_wb_en,
    input  logic [`HART_ID_W-1:0]                pipe_wb_hart_id,
    input  logic [`REG_ADDR_W-1:0]               pipe_wb_rd,
    input  logic [`XLEN-1:0]                     pipe_wb_data,
    output logic                                 rf_we,
    output logic [`HART_ID_W-1:0]                rf_hart_id,
    output logic [`REG_ADDR_W-1:0]               rf_rd,
    output logic [`XLEN-1:0]                     rf_wdata,
    output logic                                 muldiv_issue_ok,
    output logic [`HART_NUM-1:0]                 muldiv_pending,
    output logic [`HART_NUM*`REG_ADDR_W-1:0]     muldiv_pending_rd,
    output logic                                 wb_overflow
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_RW    = `REG_ADDR_W;

    logic [`XLEN-1:0]                 r_fifo_data [FIFO_DEPTH];
    logic [`HART_ID_W-1:0]            r_fifo_hart [FIFO_DEPTH];
    logic [`REG_ADDR_W-1:0]           r_fifo_rd   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]               r_wr_ptr;
    logic [c_PTR_W-1:0]               r_rd_ptr;
    logic [c_CNT_W-1:0]               r_count;
    logic [`HART_NUM-1:0]             r_pending;
    logic [`HART_NUM*`REG_ADDR_W-1:0] r_pending_rd;
    logic                             r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_clr;
    logic [`HART_ID_W-1:0] w_clr_hart;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));

`ifdef MULDIV_WB_BYPASS_EN
    assign w_bypass = muldiv_done && w_empty && !pipe_wb_en;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop frees a slot this edge, so a done arriving while full still fits.
    assign w_pop      = !pipe_wb_en && !w_empty;
    assign w_push     = muldiv_done && !w_bypass && (!w_full || w_pop);
    assign w_clr      = w_pop || w_bypass;
    assign w_clr_hart = w_pop ? r_fifo_hart[r_rd_ptr] : muldiv_done_hart_id;

    always_comb begin
        rf_we      = 1'b0;
        rf_hart_id = '0;
        rf_rd      = '0;
        rf_wdata   = '0;
        if (rst_n) begin
            if (pipe_wb_en) begin
                rf_we      = 1'b1;
                rf_hart_id = pipe_wb_hart_id;
                rf_rd      = pipe_wb_rd;
                rf_wdata   = pipe_wb_data;
            end else if (!w_empty) begin
                rf_we      = (r_fifo_rd[r_rd_ptr] != '0);
                rf_hart_id = r_fifo_hart[r_rd_ptr];
                rf_rd      = r_fifo_rd[r_rd_ptr];
                rf_wdata   = r_fifo_data[r_rd_ptr];
            end else if (w_bypass) begin
                rf_we      = (muldiv_done_rd != '0);
                rf_hart_id = muldiv_done_hart_id;
                rf_rd      = muldiv_done_rd;
                rf_wdata   = muldiv_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= muldiv_result;
            r_fifo_hart[r_wr_ptr] <= muldiv_done_hart_id;
            r_fifo_rd[r_wr_ptr]   <= muldiv_done_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (muldiv_done && !w_bypass && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Start takes precedence over a same-cycle completion for the same hart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= '0;
            r_pending_rd <= '0;
        end else begin
            for (int h = 0; h < `HART_NUM; h++) begin
                if (muldiv_start && (int'(muldiv_hart_id) == h)) begin
                    r_pending[h]                <= 1'b1;
                    r_pending_rd[h*c_RW +: c_RW] <= muldiv_rd;
                end else if (w_clr && (int'(w_clr_hart) == h)) begin
                    r_pending[h] <= 1'b0;
                end
            end
        end
    end

    assign muldiv_issue_ok   = (r_count < c_CNT_W'(FIFO_DEPTH - 1));
    assign muldiv_pending    = r_pending;
    assign muldiv_pending_rd = r_pending_rd;
    assign wb_overflow       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_wb_merge.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_wb_merge
// Brief   : Self-checking bench for muldiv_wb_merge against a queue-based
//           reference model; follows MULDIV_WB_BYPASS_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 1
`endif
`ifndef HART_NUM
`define HART_NUM 2
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module tb_muldiv_wb_merge;

    localparam int XL    = `XLEN;
    localparam int HW    = `HART_ID_W;
    localparam int HN    = `HART_NUM;
    localparam int RW    = `REG_ADDR_W;
    localparam int DEPTH = 4;
    localparam int OW    = 1 + HW + RW + XL + 1 + HN + HN*RW + 1;

    logic               clk;
    logic               rst_n;
    logic               muldiv_start;
    logic [HW-1:0]      muldiv_hart_id;
    logic [RW-1:0]      muldiv_rd;
    logic               muldiv_done;
    logic [XL-1:0]      muldiv_result;
    logic [HW-1:0]      muldiv_done_hart_id;
    logic [RW-1:0]      muldiv_done_rd;
    logic               pipe_wb_en;
    logic [HW-1:0]      pipe_wb_hart_id;
    logic [RW-1:0]      pipe_wb_rd;
    logic [XL-1:0]      pipe_wb_data;
    logic               rf_we;
    logic [HW-1:0]      rf_hart_id;
    logic [RW-1:0]      rf_rd;
    logic [XL-1:0]      rf_wdata;
    logic               muldiv_issue_ok;
    logic [HN-1:0]      muldiv_pending;
    logic [HN*RW-1:0]   muldiv_pending_rd;
    logic               wb_overflow;

    muldiv_wb_merge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .muldiv_start        (muldiv_start),
        .muldiv_hart_id      (muldiv_hart_id),
        .muldiv_rd           (muldiv_rd),
        .muldiv_done         (muldiv_done),
        .muldiv_result       (muldiv_result),
        .muldiv_done_hart_id (muldiv_done_hart_id),
        .muldiv_done_rd      (muldiv_done_rd),
        .pipe_wb_en          (pipe_wb_en),
        .pipe_wb_hart_id     (pipe_wb_hart_id),
        .pipe_wb_rd          (pipe_wb_rd),
        .pipe_wb_data        (pipe_wb_data),
        .rf_we               (rf_we),
        .rf_hart_id          (rf_hart_id),
        .rf_rd               (rf_rd),
        .rf_wdata            (rf_wdata),
        .muldiv_issue_ok     (muldiv_issue_ok),
        .muldiv_pending      (muldiv_pending),
        .muldiv_pending_rd   (muldiv_pending_rd),
        .wb_overflow         (wb_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [OW-1:0] obs;
    assign obs = {rf_we, rf_hart_id, rf_rd, rf_wdata, muldiv_issue_ok,
                  muldiv_pending, muldiv_pending_rd, wb_overflow};

    typedef struct packed {
        logic [XL-1:0] d;
        logic [HW-1:0] h;
        logic [RW-1:0] rd;
    } ent_t;

`ifdef MULDIV_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    ent_t          q[$];
    logic [HN-1:0] m_pend;
    logic [HN*RW-1:0] m_pend_rd;
    logic          m_ovf;
    logic [OW-1:0] exp_obs;
    int            errors = 0;
    int            checks = 0;

    task automatic model_reset();
        q.delete();
        m_pend    = '0;
        m_pend_rd = '0;
        m_ovf     = 1'b0;
    endtask

    // Expected outputs for the current inputs and model contents.
    task automatic predict();
        logic          we;
        logic [HW-1:0] h;
        logic [RW-1:0] rd;
        logic [XL-1:0] d;
        we = 1'b0; h = '0; rd = '0; d = '0;
        if (rst_n) begin
            if (pipe_wb_en) begin
                we = 1'b1; h = pipe_wb_hart_id; rd = pipe_wb_rd; d = pipe_wb_data;
            end else if (q.size() > 0) begin
                we = (q[0].rd != 0); h = q[0].h; rd = q[0].rd; d = q[0].d;
            end else if (BYP && muldiv_done) begin
                we = (muldiv_done_rd != 0); h = muldiv_done_hart_id;
                rd = muldiv_done_rd; d = muldiv_result;
            end
        end
        exp_obs = {we, h, rd, d, (q.size() < DEPTH - 1), m_pend, m_pend_rd, m_ovf};
    endtask

    task automatic model_update();
        bit            clr;
        bit            byp;
        logic [HW-1:0] ch;
        clr = 0; ch = '0;
        byp = BYP && muldiv_done && (q.size() == 0) && !pipe_wb_en;
        if (!pipe_wb_en && q.size() > 0) begin
            ch = q[0].h; clr = 1;
            void'(q.pop_front());
        end else if (byp) begin
            ch = muldiv_done_hart_id; clr = 1;
        end
        if (muldiv_done && !byp) begin
            if (q.size() < DEPTH) q.push_back('{muldiv_result, muldiv_done_hart_id, muldiv_done_rd});
            else m_ovf = 1'b1;
        end
        if (clr) m_pend[ch] = 1'b0;
        if (muldiv_start) begin
            m_pend[muldiv_hart_id] = 1'b1;
            m_pend_rd[int'(muldiv_hart_id)*RW +: RW] = muldiv_rd;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        muldiv_start = 0; muldiv_hart_id = '0; muldiv_rd = '0;
        muldiv_done = 0; muldiv_result = '0; muldiv_done_hart_id = '0; muldiv_done_rd = '0;
        pipe_wb_en = 0; pipe_wb_hart_id = '0; pipe_wb_rd = '0; pipe_wb_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        pipe_wb_en = 1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_wdata !== '0 || rf_rd !== '0) begin
            errors++; $display("FAIL reset_rf: got we=%b rd=%0d data=%h want 0", rf_we, rf_rd, rf_wdata);
        end
        checks++;
        if (muldiv_pending !== '0 || muldiv_issue_ok !== 1'b1 || wb_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_state: got pend=%b ok=%b ovf=%b want 0 1 0",
                               muldiv_pending, muldiv_issue_ok, wb_overflow);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_result();
        muldiv_start = 1; muldiv_hart_id = 1; muldiv_rd = 7;
        #1; predict(); checks++;
        if (obs !== exp_obs) begin errors++; $display("FAIL single_start: got %h want %h", obs, exp_obs); end
        advance();
        idle_inputs();
        muldiv_done = 1; muldiv_result = 32'h15; muldiv_done_hart_id = 1; muldiv_done_rd = 7;
        #1; predict(); checks++;
        if (obs !== exp_obs) begin errors++; $display("FAIL single_done: got %h want %h", obs, exp_obs); end
`ifdef MULDIV_WB_BYPASS_EN
        checks++;
        if (!(rf_we === 1'b1 && rf_rd === 5'd7 && rf_hart_id === 1 && rf_wdata === 32'h15)) begin
            errors++; $display("FAIL single_bypass: got we=%b rd=%0d h=%0d d=%h want 1 7 1 15",
                               rf_we, rf_rd, rf_hart_id, rf_wdata);
        end
`endif
        advance();
        idle_inputs();
        #1; predict(); checks++;
        if (obs !== exp_obs) begin errors++; $display("FAIL single_n1: got %h want %h", obs, exp_obs); end
`ifndef MULDIV_WB_BYPASS_EN
        checks++;
        if (!(rf_we === 1'b1 && rf_rd === 5'd7 && rf_hart_id === 1 && rf_wdata === 32'h15 &&
              muldiv_pending[1] === 1'b1)) begin
            errors++; $display("FAIL single_write: got we=%b rd=%0d h=%0d d=%h p=%b want 1 7 1 15 p1",
                               rf_we, rf_rd, rf_hart_id, rf_wdata, muldiv_pending);
        end
`endif
        advance();
        #1; checks++;
        if (muldiv_pending[1] !== 1'b0) begin
            errors++; $display("FAIL single_clear: got pend=%b want bit1=0", muldiv_pending);
        end
    endtask

    task automatic test_pipe_priority();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            pipe_wb_en = (i < 3);
            pipe_wb_data = 32'hC000_0000 + i; pipe_wb_rd = RW'(10 + i); pipe_wb_hart_id = HW'(i % 2);
            if (i == 0) begin
                muldiv_done = 1; muldiv_result = 32'hAA; muldiv_done_rd = 5; muldiv_done_hart_id = 0;
            end
            #1; predict(); checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL prio_model[%0d]: got %h want %h", i, obs, exp_obs); end
            if (i < 3) begin
                checks++;
                if (rf_we !== 1'b1 || rf_wdata !== 32'hC000_0000 + i) begin
                    errors++; $display("FAIL prio_pipe[%0d]: got we=%b d=%h want pipe data", i, rf_we, rf_wdata);
                end
            end else if (i == 3) begin
                checks++;
                if (rf_we !== 1'b1 || rf_wdata !== 32'hAA || rf_rd !== 5'd5) begin
                    errors++; $display("FAIL prio_muldiv: got we=%b rd=%0d d=%h want 1 5 aa", rf_we, rf_rd, rf_wdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_fill_overflow();
        for (int k = 0; k <= DEPTH; k++) begin
            idle_inputs();
            pipe_wb_en = 1; pipe_wb_data = 32'h1111_0000; pipe_wb_rd = 1;
            muldiv_done = 1; muldiv_result = 32'hD000 + k;
            muldiv_done_rd = RW'(k + 1); muldiv_done_hart_id = HW'(k % 2);
            #1; predict(); checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL fill_model[%0d]: got %h want %h", k, obs, exp_obs); end
            checks++;
            if (muldiv_issue_ok !== (k < DEPTH - 1)) begin
                errors++; $display("FAIL fill_issue_ok[%0d]: got %b want %b", k, muldiv_issue_ok, (k < DEPTH - 1));
            end
            advance();
        end
        idle_inputs();
        for (int j = 0; j < DEPTH + 1; j++) begin
            #1; predict(); checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL drain_model[%0d]: got %h want %h", j, obs, exp_obs); end
            if (j < DEPTH) begin
                checks++;
                if (rf_wdata !== 32'hD000 + j || wb_overflow !== 1'b1) begin
                    errors++; $display("FAIL drain_order[%0d]: got d=%h ovf=%b want %h 1",
                                       j, rf_wdata, wb_overflow, 32'hD000 + j);
                end
            end
            advance();
        end
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        muldiv_start = 1; muldiv_hart_id = 0; muldiv_rd = 4;
        advance();
        idle_inputs();
        muldiv_done = 1; muldiv_result = 32'h77; muldiv_done_hart_id = 0; muldiv_done_rd = 0;
        for (int i = 0; i < 2; i++) begin
            #1; predict(); checks++;
            if (obs !== exp_obs || rf_we !== 1'b0) begin
                errors++; $display("FAIL rd0_nowrite[%0d]: got %h want %h", i, obs, exp_obs);
            end
            advance();
            idle_inputs();
        end
        #1; checks++;
        if (muldiv_pending[0] !== 1'b0) begin
            errors++; $display("FAIL rd0_clear: got pend=%b want bit0=0", muldiv_pending);
        end
    endtask

    task automatic test_start_pop_same();
        idle_inputs();
        pipe_wb_en = 1; pipe_wb_rd = 1; pipe_wb_hart_id = 1; pipe_wb_data = 32'h5;
        muldiv_done = 1; muldiv_result = 32'h33; muldiv_done_hart_id = 0; muldiv_done_rd = 3;
        advance();
        idle_inputs();
        muldiv_start = 1; muldiv_hart_id = 0; muldiv_rd = 9;
        #1; predict(); checks++;
        if (obs !== exp_obs || rf_rd !== 5'd3) begin
            errors++; $display("FAIL startpop_model: got %h want %h", obs, exp_obs);
        end
        advance();
        idle_inputs();
        #1; checks++;
        if (muldiv_pending[0] !== 1'b1 || muldiv_pending_rd[RW-1:0] !== 5'd9) begin
            errors++; $display("FAIL startpop_setwins: got p=%b rd=%0d want 1 9",
                               muldiv_pending[0], muldiv_pending_rd[RW-1:0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 0;
                model_reset();
            end
            if (i == 203) rst_n = 1;
            muldiv_start        = ($urandom_range(0, 9) < 3);
            muldiv_hart_id      = HW'($urandom_range(0, HN - 1));
            muldiv_rd           = RW'($urandom_range(0, 31));
            muldiv_done         = ($urandom_range(0, 9) < 4);
            muldiv_result       = $urandom;
            muldiv_done_hart_id = HW'($urandom_range(0, HN - 1));
            muldiv_done_rd      = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom_range(1, 31));
            pipe_wb_en          = ($urandom_range(0, 9) < 6);
            pipe_wb_hart_id     = HW'($urandom_range(0, HN - 1));
            pipe_wb_rd          = RW'($urandom_range(0, 31));
            pipe_wb_data        = $urandom;
            #1; predict(); checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_obs); end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_result();
        test_pipe_priority();
        test_fill_overflow();
        test_rd_zero();
        test_start_pop_same();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
